// File: rtl/zr_pkg.sv
// Shared constants and the next-PC select encoding for the Zero-RISC-V fetch stage.
package zr_pkg;

   localparam int          XLEN           = 32;
   localparam int          PC_INC         = 4;
   localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      NPC_SEQ  = 2'd0,
      NPC_REL  = 2'd1,
      NPC_JALR = 2'd2
   } npc_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority decode (JALR > PC-relative > sequential) plus the two PC adders.
// Latency: purely combinational. Backpressure: none; stall gating lives in the register stage.
// Arithmetic wraps silently modulo 2^size.
module pc_next_sel
   import zr_pkg::*;
#(
   parameter int size = XLEN
) (
   input  logic [size-1:0] pc,
   input  logic            mpc,
   input  logic            jalr,
   input  logic [size-1:0] imm,
   input  logic [size-1:0] imm_rs,
   output logic [size-1:0] next_pc
);

   localparam logic [size-1:0] INC  = size'(PC_INC);
   localparam logic [size-1:0] LSB1 = size'(1);

   npc_sel_t        sel;
   logic [size-1:0] seq_pc;
   logic [size-1:0] rel_pc;
   logic [size-1:0] jalr_pc;

   assign seq_pc  = pc + INC;
   assign rel_pc  = pc + imm;
   // JALR targets always land on an even address.
   assign jalr_pc = imm_rs & ~LSB1;

   always_comb begin
      sel = NPC_SEQ;
      if (jalr)
         sel = NPC_JALR;
      else if (mpc)
         sel = NPC_REL;
   end

   always_comb begin
      next_pc = seq_pc;
      case (sel)
         NPC_JALR: next_pc = jalr_pc;
         NPC_REL:  next_pc = rel_pc;
         default:  next_pc = seq_pc;
      endcase
   end

endmodule

// File: rtl/program_counter.sv
// Fetch-stage PC register with link-address output; PC_STALL_EN adds a stall input that freezes the PC.
// Latency: next-PC select visible on PC_Addr one edge later; PC_save follows PC_Addr combinationally.
// Backpressure: none by default; with PC_STALL_EN, stall holds the PC (reset still wins).
module program_counter
   import zr_pkg::*;
#(
   parameter int              size       = XLEN,
   parameter logic [size-1:0] RESET_ADDR = size'(RESET_ADDR_DEF)
) (
   input  logic            clk,
   input  logic            reset,
`ifdef PC_STALL_EN
   input  logic            stall,
`endif
   input  logic            MPC,
   input  logic            JALR,
   input  logic [size-1:0] IMM,
   input  logic [size-1:0] IMM_rs,
   output logic [size-1:0] PC_Addr,
   output logic [size-1:0] PC_save
);

   localparam logic [size-1:0] INC = size'(PC_INC);

   logic [size-1:0] pc_q;
   logic [size-1:0] next_pc;
   logic            hold;

`ifdef PC_STALL_EN
   assign hold = stall;
`else
   assign hold = 1'b0;
`endif

   pc_next_sel #(
      .size (size)
   ) u_pc_next_sel (
      .pc      (pc_q),
      .mpc     (MPC),
      .jalr    (JALR),
      .imm     (IMM),
      .imm_rs  (IMM_rs),
      .next_pc (next_pc)
   );

   always_ff @(posedge clk) begin
      if (reset)
         pc_q <= RESET_ADDR;
      else if (!hold)
         pc_q <= next_pc;
   end

   assign PC_Addr = pc_q;
   assign PC_save = pc_q + INC;

endmodule

// File: tb/tb_program_counter.sv
// Directed table-driven bench for program_counter; the stall sequence runs only when PC_STALL_EN is defined.
module tb_program_counter;

   typedef struct {
      logic        rst;
      logic        mpc;
      logic        jalr;
      logic [31:0] imm;
      logic [31:0] imm_rs;
      logic [31:0] exp_pc;
      logic [31:0] exp_save;
   } vec_t;

   localparam int NVEC = 24;

   logic        clk;
   logic        reset;
   logic        MPC;
   logic        JALR;
   logic [31:0] IMM;
   logic [31:0] IMM_rs;
   logic [31:0] PC_Addr;
   logic [31:0] PC_save;
`ifdef PC_STALL_EN
   logic        stall;
`endif

   int tests;
   int fails;
   vec_t vecs [NVEC];

   program_counter dut (
      .clk     (clk),
      .reset   (reset),
`ifdef PC_STALL_EN
      .stall   (stall),
`endif
      .MPC     (MPC),
      .JALR    (JALR),
      .IMM     (IMM),
      .IMM_rs  (IMM_rs),
      .PC_Addr (PC_Addr),
      .PC_save (PC_save)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic m, logic j, logic [31:0] i, logic [31:0] rs,
                               logic [31:0] pc, logic [31:0] sv);
      vec_t v;
      v.rst = r; v.mpc = m; v.jalr = j; v.imm = i; v.imm_rs = rs;
      v.exp_pc = pc; v.exp_save = sv;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
   task automatic step(input logic r, input logic m, input logic j,
                       input logic [31:0] i, input logic [31:0] rs);
      @(negedge clk);
      reset = r; MPC = m; JALR = j; IMM = i; IMM_rs = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1; MPC = 1'b0; JALR = 1'b0; IMM = '0; IMM_rs = '0;
`ifdef PC_STALL_EN
      stall = 1'b0;
`endif

      //            rst  mpc  jalr imm            imm_rs         exp_pc         exp_save
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'd0,        32'd0,        32'd0,        32'd4);
      vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'd0,        32'd0,        32'd0,        32'd4);
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'd4,        32'd8);
      vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'd8,        32'd12);
      vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'd12,       32'd16);
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'd16,       32'd20);
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'd20,       32'd24);
      vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'd12,       32'd0,        32'd32,       32'd36);
      vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'd12,       32'd0,        32'd44,       32'd48);
      vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'd12,       32'd0,        32'd56,       32'd60);
      vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0,       32'd48,       32'd52);
      vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'd0,        32'd100,      32'd100,      32'd104);
      vecs[12] = mk(1'b0, 1'b0, 1'b1, 32'd0,        32'd100,      32'd100,      32'd104);
      vecs[13] = mk(1'b0, 1'b0, 1'b1, 32'd0,        32'd101,      32'd100,      32'd104);
      vecs[14] = mk(1'b0, 1'b1, 1'b1, 32'd12,       32'd100,      32'd100,      32'd104);
      vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'd12,       32'd100,      32'd104,      32'd108);
      vecs[16] = mk(1'b0, 1'b0, 1'b1, 32'd0,        32'd200,      32'd200,      32'd204);
      vecs[17] = mk(1'b1, 1'b1, 1'b0, 32'd12,       32'd0,        32'd0,        32'd4);
      vecs[18] = mk(1'b0, 1'b0, 1'b1, 32'd0,        32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd0);
      vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'd0,        32'd4);
      vecs[20] = mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'd4,        32'd8);
      vecs[21] = mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_1235, 32'h0000_1234, 32'h0000_1238);
      vecs[22] = mk(1'b0, 1'b1, 1'b0, 32'd2,        32'd0,        32'h0000_1236, 32'h0000_123A);
      vecs[23] = mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        32'h0000_123A, 32'h0000_123E);

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].rst, vecs[i].mpc, vecs[i].jalr, vecs[i].imm, vecs[i].imm_rs);
         check($sformatf("vec%0d pc_addr", i), PC_Addr, vecs[i].exp_pc);
         check($sformatf("vec%0d pc_save", i), PC_save, vecs[i].exp_save);
      end

      // PC_save must track PC_Addr without waiting for another edge.
      step(1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0040);
      @(negedge clk);
      check("save_mid_cycle", PC_save, 32'h0000_0044);

`ifdef PC_STALL_EN
      step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("stall_pre", PC_Addr, 32'd8);
      @(negedge clk);
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 1'b1, 1'b1, 32'd100, 32'd300);
         check($sformatf("stall_hold%0d", c), PC_Addr, 32'd8);
      end
      @(negedge clk);
      stall = 1'b0;
      step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("stall_release", PC_Addr, 32'd12);
      @(negedge clk);
      stall = 1'b1;
      step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      check("stall_reset", PC_Addr, 32'd0);
      @(negedge clk);
      stall = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
